// File: rtl/triadic_control_fsm_if.sv
// Control bus between the sequencer and the triadic register-file datapath:
// the instruction word going in and the datapath control strobes coming out.
interface triadic_control_fsm_if;
   logic [31:0] instr;
   logic        Oprnd1Sel;
   logic        Oprnd2Sel;
   logic        ExtnCntl;
   logic        RDSEL;
   logic        DinSel2;
   logic        WE;
   logic        NextPC;

   modport master (
      input  instr,
      output Oprnd1Sel, Oprnd2Sel, ExtnCntl, RDSEL, DinSel2, WE, NextPC
   );

   modport slave (
      output instr,
      input  Oprnd1Sel, Oprnd2Sel, ExtnCntl, RDSEL, DinSel2, WE, NextPC
   );
endinterface

// File: rtl/triadic_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the triadic datapath
// strobes, with free-running and single-step execution and a halt opcode.
module triadic_control_fsm #(
   parameter int unsigned CNT_W   = 16,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  step,
   triadic_control_fsm_if.master bus,
   output logic                  instr_done,
   output logic                  halted,
   output logic                  illegal,
   output logic [CNT_W-1:0]      retired
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned INSTR_W = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [INSTR_W-1:0] ir;
   logic               step_q;

   logic [OP_W-1:0]    opcode_c;
   logic               dec_o1_c;
   logic               dec_o2_c;
   logic               dec_ext_c;
   logic               dec_rdsel_c;
   logic               dec_din2_c;
   logic               dec_wr_c;
   logic               dec_npc_c;
   logic               dec_legal_c;
   logic               in_window_c;

   // Register fields are consumed by the datapath, not the sequencer.
   logic               unused_ir_fields;
   assign unused_ir_fields = ^{ir[25:0], bus.instr[25:0]};

   // On the FETCH->DECODE edge ir is still being loaded, so decode the live word.
   always_comb begin
      opcode_c = ir[31:26];
      if (state == FETCH) begin
         opcode_c = bus.instr[31:26];
      end
   end

   // Opcode decode; undefined opcodes behave as a NOP that still advances PC.
   always_comb begin
      dec_o1_c    = 1'b0;
      dec_o2_c    = 1'b0;
      dec_ext_c   = 1'b0;
      dec_rdsel_c = 1'b0;
      dec_din2_c  = 1'b0;
      dec_wr_c    = 1'b0;
      dec_npc_c   = 1'b1;
      dec_legal_c = 1'b1;
      if (opcode_c == HALT_OP) begin
         dec_npc_c = 1'b0;
      end else begin
         unique case (opcode_c)
            6'h00: begin
               dec_rdsel_c = 1'b1;
               dec_wr_c    = 1'b1;
            end
            6'h01: begin
               dec_o2_c  = 1'b1;
               dec_ext_c = 1'b1;
               dec_wr_c  = 1'b1;
            end
            6'h02: begin
               dec_o2_c = 1'b1;
               dec_wr_c = 1'b1;
            end
            6'h03: begin
               dec_o2_c   = 1'b1;
               dec_ext_c  = 1'b1;
               dec_din2_c = 1'b1;
               dec_wr_c   = 1'b1;
            end
            6'h05: begin
               dec_o1_c  = 1'b1;
               dec_o2_c  = 1'b1;
               dec_ext_c = 1'b1;
               dec_wr_c  = 1'b1;
            end
            default: begin
               dec_legal_c = 1'b0;
            end
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (run || (step && !step_q)) begin
               state_next = FETCH;
            end
         end
         FETCH:  state_next = DECODE;
         DECODE: state_next = EXEC;
         EXEC:   state_next = WB;
         WB: begin
            if (opcode_c == HALT_OP) begin
               state_next = HALT;
            end else if (run) begin
               state_next = FETCH;
            end else begin
               state_next = IDLE;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   assign in_window_c = (state_next == DECODE) || (state_next == EXEC) ||
                        (state_next == WB);

   // State, instruction register and registered strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         step_q        <= 1'b0;
         ir            <= '0;
         bus.Oprnd1Sel <= 1'b0;
         bus.Oprnd2Sel <= 1'b0;
         bus.ExtnCntl  <= 1'b0;
         bus.RDSEL     <= 1'b0;
         bus.DinSel2   <= 1'b0;
         bus.WE        <= 1'b0;
         bus.NextPC    <= 1'b0;
         instr_done    <= 1'b0;
         halted        <= 1'b0;
         illegal       <= 1'b0;
         retired       <= '0;
      end else begin
         state         <= state_next;
         step_q        <= step;
         if (state == FETCH) begin
            ir <= bus.instr;
         end
         bus.Oprnd1Sel <= in_window_c && dec_o1_c;
         bus.Oprnd2Sel <= in_window_c && dec_o2_c;
         bus.ExtnCntl  <= in_window_c && dec_ext_c;
         bus.RDSEL     <= in_window_c && dec_rdsel_c;
         bus.DinSel2   <= in_window_c && dec_din2_c;
         bus.WE        <= (state_next == WB) && dec_wr_c;
         bus.NextPC    <= (state_next == WB) && dec_npc_c;
         instr_done    <= (state_next == WB);
         halted        <= halted || (state_next == HALT);
         if (state == WB) begin
            illegal <= illegal || !dec_legal_c;
            retired <= retired + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_triadic_control_fsm.sv
// Directed self-checking bench for triadic_control_fsm: run, step, decode,
// illegal, halt, mid-instruction reset and counter wrap scenarios.
module tb_triadic_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        step;
   logic        instr_done;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;

   logic        reset2;
   logic        run2;
   logic        step2;
   logic        instr_done2;
   logic        halted2;
   logic        illegal2;
   logic [1:0]  retired2;

   int n_cmp = 0;
   int n_bad = 0;

   triadic_control_fsm_if bus ();
   triadic_control_fsm_if bus2 ();

   triadic_control_fsm #(.CNT_W(16), .HALT_OP(6'h3F)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .bus(bus),
      .instr_done(instr_done), .halted(halted), .illegal(illegal),
      .retired(retired)
   );

   triadic_control_fsm #(.CNT_W(2), .HALT_OP(6'h3F)) dut2 (
      .clk(clk), .reset(reset2), .run(run2), .step(step2), .bus(bus2),
      .instr_done(instr_done2), .halted(halted2), .illegal(illegal2),
      .retired(retired2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   function automatic logic [7:0] ctl();
      return {bus.Oprnd1Sel, bus.Oprnd2Sel, bus.ExtnCntl, bus.RDSEL,
              bus.DinSel2, bus.WE, bus.NextPC, instr_done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      step  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.instr = 32'h0022_0800;
      do_reset();
      n_cmp++;
      if (ctl() !== 8'h00) begin
         $display("FAIL reset_ctl: got %h expected %h", ctl(), 8'h00);
         n_bad++;
      end
      n_cmp++;
      if ({halted, illegal, retired} !== 18'h0) begin
         $display("FAIL reset_status: got %h expected %h", {halted, illegal, retired}, 18'h0);
         n_bad++;
      end
      n_cmp++;
      if (dut.state !== 3'd0) begin
         $display("FAIL reset_state: got %0d expected %0d", dut.state, 0);
         n_bad++;
      end
   endtask

   task automatic test_run_rtype();
      int we_cnt = 0;
      do_reset();
      bus.instr = 32'h0022_0800;
      run = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         n_cmp++;
         if ({bus.WE, bus.NextPC} !== {2{(i % 4) == 0}}) begin
            $display("FAIL run_we_npc[%0d]: got %b expected %b", i, {bus.WE, bus.NextPC}, {2{(i % 4) == 0}});
            n_bad++;
         end
         if (bus.WE) begin
            we_cnt++;
            n_cmp++;
            if ({bus.RDSEL, bus.Oprnd2Sel} !== 2'b10) begin
               $display("FAIL run_rdsel_o2: got %b expected %b", {bus.RDSEL, bus.Oprnd2Sel}, 2'b10);
               n_bad++;
            end
         end
      end
      n_cmp++;
      if (we_cnt !== 3) begin
         $display("FAIL run_we_count: got %0d expected %0d", we_cnt, 3);
         n_bad++;
      end
      tick();
      n_cmp++;
      if (retired !== 16'd3) begin
         $display("FAIL run_retired: got %0d expected %0d", retired, 3);
         n_bad++;
      end
      run = 1'b0;
   endtask

   task automatic test_step_addi();
      int done_cnt = 0;
      do_reset();
      bus.instr = 32'h0400_FFFF;
      step = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1) begin
            n_cmp++;
            if (bus.Oprnd2Sel !== 1'b0) begin
               $display("FAIL step_fetch_o2: got %b expected %b", bus.Oprnd2Sel, 1'b0);
               n_bad++;
            end
         end
         if (i == 2) begin
            n_cmp++;
            if (bus.Oprnd2Sel !== 1'b1) begin
               $display("FAIL step_decode_o2: got %b expected %b", bus.Oprnd2Sel, 1'b1);
               n_bad++;
            end
         end
         if (i == 4) begin
            n_cmp++;
            if ({bus.Oprnd2Sel, bus.ExtnCntl, bus.RDSEL, bus.WE, instr_done} !== 5'b11011) begin
               $display("FAIL step_wb_ctl: got %b expected %b",
                        {bus.Oprnd2Sel, bus.ExtnCntl, bus.RDSEL, bus.WE, instr_done}, 5'b11011);
               n_bad++;
            end
         end
         if (instr_done) done_cnt++;
      end
      n_cmp++;
      if (done_cnt !== 1) begin
         $display("FAIL step_single: got %0d expected %0d", done_cnt, 1);
         n_bad++;
      end
      n_cmp++;
      if (dut.state !== 3'd0 || retired !== 16'd1) begin
         $display("FAIL step_idle_retired: got state %0d ret %0d expected state 0 ret 1", dut.state, retired);
         n_bad++;
      end
      // A new edge raised while the FSM is busy must be dropped.
      done_cnt = 0;
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (instr_done) done_cnt++;
      end
      n_cmp++;
      if (done_cnt !== 1 || retired !== 16'd2) begin
         $display("FAIL step_busy_edge: got done %0d ret %0d expected done 1 ret 2", done_cnt, retired);
         n_bad++;
      end
      step = 1'b0;
   endtask

   task automatic test_load_auipc();
      do_reset();
      bus.instr = 32'h0C00_0004;
      run = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (ctl() !== 8'b0110_1111) begin
         $display("FAIL load_wb: got %b expected %b", ctl(), 8'b0110_1111);
         n_bad++;
      end
      bus.instr = 32'h1400_0010;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (ctl() !== 8'b1110_0111) begin
         $display("FAIL auipc_wb: got %b expected %b", ctl(), 8'b1110_0111);
         n_bad++;
      end
      run = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      bus.instr = 32'hA800_0000;
      run = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if ({bus.WE, bus.NextPC, instr_done, illegal} !== 4'b0110) begin
         $display("FAIL illegal_wb: got %b expected %b", {bus.WE, bus.NextPC, instr_done, illegal}, 4'b0110);
         n_bad++;
      end
      bus.instr = 32'h0022_0800;
      tick();
      n_cmp++;
      if (illegal !== 1'b1) begin
         $display("FAIL illegal_set: got %b expected %b", illegal, 1'b1);
         n_bad++;
      end
      for (int i = 0; i < 7; i++) tick();
      n_cmp++;
      if ({bus.WE, illegal} !== 2'b11) begin
         $display("FAIL illegal_sticky: got %b expected %b", {bus.WE, illegal}, 2'b11);
         n_bad++;
      end
      run = 1'b0;
   endtask

   task automatic test_halt();
      int done_cnt = 0;
      do_reset();
      bus.instr = 32'hFC00_0000;
      run = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if ({bus.WE, bus.NextPC, instr_done, halted} !== 4'b0010) begin
         $display("FAIL halt_wb: got %b expected %b", {bus.WE, bus.NextPC, instr_done, halted}, 4'b0010);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({halted, ctl()} !== 9'h100) begin
         $display("FAIL halt_rise: got %h expected %h", {halted, ctl()}, 9'h100);
         n_bad++;
      end
      bus.instr = 32'h0022_0800;
      for (int i = 0; i < 12; i++) begin
         step = i[1];
         run  = i[0];
         tick();
         if (instr_done || ctl() != 8'h00) done_cnt++;
      end
      n_cmp++;
      if (done_cnt !== 0 || halted !== 1'b1 || retired !== 16'd1) begin
         $display("FAIL halt_hold: got act %0d halted %b ret %0d expected act 0 halted 1 ret 1",
                  done_cnt, halted, retired);
         n_bad++;
      end
      run  = 1'b0;
      step = 1'b0;
   endtask

   task automatic test_reset_mid();
      int we_cnt = 0;
      do_reset();
      bus.instr = 32'h0022_0800;
      run = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({ctl(), retired} !== 24'h0) begin
         $display("FAIL reset_exec: got %h expected %h", {ctl(), retired}, 24'h0);
         n_bad++;
      end
      reset = 1'b0;
      run   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.WE) we_cnt++;
      end
      n_cmp++;
      if (we_cnt !== 0 || retired !== 16'd0) begin
         $display("FAIL reset_exec_after: got we %0d ret %0d expected we 0 ret 0", we_cnt, retired);
         n_bad++;
      end
      run = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({ctl(), retired} !== 24'h0) begin
         $display("FAIL reset_wb: got %h expected %h", {ctl(), retired}, 24'h0);
         n_bad++;
      end
      reset = 1'b0;
      run   = 1'b0;
   endtask

   task automatic test_wrap();
      bus2.instr = 32'h0022_0800;
      run2  = 1'b1;
      reset2 = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      n_cmp++;
      if (retired2 !== 2'd0) begin
         $display("FAIL wrap_four: got %0d expected %0d", retired2, 0);
         n_bad++;
      end
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (retired2 !== 2'd1) begin
         $display("FAIL wrap_five: got %0d expected %0d", retired2, 1);
         n_bad++;
      end
      run2 = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      run    = 1'b0;
      step   = 1'b0;
      reset2 = 1'b1;
      run2   = 1'b0;
      step2  = 1'b0;
      bus.instr  = 32'h0;
      bus2.instr = 32'h0;
      tick();
      tick();
      test_reset();
      test_run_rtype();
      test_step_addi();
      test_load_auipc();
      test_illegal();
      test_halt();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
